led_pwm_port: RTL and testbench

- Memory-mapped LED output peripheral on the 6502 CPU bus, inside top.
- Sits directly downstream of the CPU: consumes address, write data and write-enable, and drives the four board LEDs (leds[3:0]).
- Provides per-LED 8-bit PWM brightness, a shared programmable prescaler, per-LED blink gating and an output invert.
- Returns registered read data in the synchronous-read timing the CPU expects: data valid the cycle after the address.

---
 rtl/led_pwm_port.sv | 131 +++++++++++++
 tb/tb_led_pwm_port.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_port.sv
// led_pwm_port: memory-mapped LED peripheral on the 6502 bus.
// Per-LED 8-bit PWM duty, shared prescaler, per-LED blink gating and
// output invert. Read data is registered and valid the cycle after the
// address, qualified by rsel for the top-level read mux.
module led_pwm_port #(
  parameter logic [15:0] BASE_ADDR = 16'hD000,
  parameter int unsigned N_LEDS    = 4
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [7:0]        wdata,
  input  logic              we,
  output logic [7:0]        rdata,
  output logic              rsel,
  output logic [N_LEDS-1:0] leds
);

  localparam logic [2:0] OFF_DUTY0    = 3'd0;
  localparam logic [2:0] OFF_DUTY1    = 3'd1;
  localparam logic [2:0] OFF_DUTY2    = 3'd2;
  localparam logic [2:0] OFF_DUTY3    = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_PRESCALE = 3'd5;
  localparam logic [2:0] OFF_PWMCNT   = 3'd6;

  logic                   hit;
  logic                   wr_en;
  logic                   rd_en;
  logic [2:0]             off;

  logic [N_LEDS-1:0][7:0] duty_q, duty_d;
  logic [7:0]             ctrl_q, ctrl_d;
  logic [7:0]             presc_q, presc_d;
  logic [7:0]             presc_cnt_q, presc_cnt_d;
  logic [7:0]             pwm_cnt_q, pwm_cnt_d;
  logic [7:0]             blink_cnt_q, blink_cnt_d;
  logic [N_LEDS-1:0]      leds_q, leds_d;
  logic [7:0]             rdata_q, rdata_d;
  logic                   rsel_q, rsel_d;

  logic                   tick;
  logic                   wrap;
  logic [7:0]             rd_val;

  assign hit   = (addr[15:3] == BASE_ADDR[15:3]);
  assign off   = addr[2:0];
  assign wr_en = hit & we;
  assign rd_en = hit & ~we;

  // Register file write decode; CTRL bits 3:2 are never stored
  always_comb begin
    duty_d  = duty_q;
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    if (wr_en) begin
      case (off)
        OFF_DUTY0, OFF_DUTY1, OFF_DUTY2, OFF_DUTY3: duty_d[off[1:0]] = wdata;
        OFF_CTRL:     ctrl_d  = {wdata[7:4], 2'b00, wdata[1:0]};
        OFF_PRESCALE: presc_d = wdata;
        default: ;
      endcase
    end
  end

  assign tick = (presc_cnt_q == presc_q);
  assign wrap = tick && (pwm_cnt_q == 8'hFF);

  // Prescaler, PWM and blink counters; a PRESCALE write restarts the
  // prescaler but a coincident tick still advances the PWM counter
  always_comb begin
    if (wr_en && (off == OFF_PRESCALE)) begin
      presc_cnt_d = '0;
    end else if (tick) begin
      presc_cnt_d = '0;
    end else begin
      presc_cnt_d = presc_cnt_q + 8'd1;
    end
    pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    blink_cnt_d = wrap ? blink_cnt_q + 8'd1 : blink_cnt_q;
  end

  // Read mux on pre-edge register contents, and per-LED compare
  always_comb begin
    case (off)
      OFF_DUTY0, OFF_DUTY1, OFF_DUTY2, OFF_DUTY3: rd_val = duty_q[off[1:0]];
      OFF_CTRL:     rd_val = ctrl_q;
      OFF_PRESCALE: rd_val = presc_q;
      OFF_PWMCNT:   rd_val = pwm_cnt_q;
      default:      rd_val = '0;
    endcase
    rdata_d = rd_en ? rd_val : '0;
    rsel_d  = rd_en;
    leds_d  = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      leds_d[i] = (ctrl_q[0]
                   && (duty_q[i] > pwm_cnt_q)
                   && !(ctrl_q[4+i] && blink_cnt_q[7])) ^ ctrl_q[1];
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      duty_q      <= '0;
      ctrl_q      <= '0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      leds_q      <= '0;
      rdata_q     <= '0;
      rsel_q      <= 1'b0;
    end else begin
      duty_q      <= duty_d;
      ctrl_q      <= ctrl_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      leds_q      <= leds_d;
      rdata_q     <= rdata_d;
      rsel_q      <= rsel_d;
    end
  end

  assign rdata = rdata_q;
  assign rsel  = rsel_q;
  assign leds  = leds_q;

endmodule

// File: tb/tb_led_pwm_port.sv
// Bench for led_pwm_port: behavioural model compared every cycle, plus
// directed literal checks for reset, readback, duty, latency, prescaler,
// blink and invert, followed by randomized bus traffic.
module tb_led_pwm_port;

  localparam logic [15:0] BASE = 16'hD000;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  rdata;
  logic        rsel;
  logic [3:0]  leds;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  bit          run_chk     = 1'b0;

  led_pwm_port #(.BASE_ADDR(BASE), .N_LEDS(4)) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .rdata  (rdata),
    .rsel   (rsel),
    .leds   (leds)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural model: total tick count T gives pwm = T mod 256 and
  // blink phase = (T mod 65536) >= 32768.
  logic [7:0]  m_duty [4];
  logic [7:0]  m_ctrl;
  logic [7:0]  m_presc;
  logic [7:0]  m_pcnt;
  int unsigned m_T;
  logic [7:0]  m_rdata;
  logic        m_rsel;
  logic [3:0]  m_leds;

  logic m_hit;
  logic m_tick;
  assign m_hit  = (addr[15:3] == BASE[15:3]);
  assign m_tick = (m_pcnt == m_presc);

  function automatic logic [3:0] model_leds();
    logic [3:0] r;
    int unsigned pwm;
    bit blink_off;
    pwm = m_T % 256;
    blink_off = (m_T % 65536) >= 32768;
    for (int i = 0; i < 4; i++) begin
      bit on;
      on = m_ctrl[0] && (int'(m_duty[i]) > int'(pwm)) && !(m_ctrl[4+i] && blink_off);
      r[i] = on ^ m_ctrl[1];
    end
    return r;
  endfunction

  function automatic logic [7:0] model_read(input logic [2:0] o);
    case (o)
      3'd0, 3'd1, 3'd2, 3'd3: return m_duty[o[1:0]];
      3'd4: return m_ctrl & 8'hF3;
      3'd5: return m_presc;
      3'd6: return 8'(m_T % 256);
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_duty[i] <= 8'h00;
      m_ctrl  <= 8'h00;
      m_presc <= 8'h00;
      m_pcnt  <= 8'h00;
      m_T     <= 0;
      m_rdata <= 8'h00;
      m_rsel  <= 1'b0;
      m_leds  <= 4'b0000;
    end else begin
      m_leds  <= model_leds();
      m_rsel  <= m_hit && !we;
      m_rdata <= (m_hit && !we) ? model_read(addr[2:0]) : 8'h00;
      if (m_tick) m_T <= m_T + 1;
      if (m_hit && we && addr[2:0] == 3'd5) m_pcnt <= 8'h00;
      else if (m_tick)                      m_pcnt <= 8'h00;
      else                                  m_pcnt <= m_pcnt + 8'd1;
      if (m_hit && we) begin
        case (addr[2:0])
          3'd0, 3'd1, 3'd2, 3'd3: m_duty[addr[1:0]] <= wdata;
          3'd4: m_ctrl  <= wdata;
          3'd5: m_presc <= wdata;
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge sys_clk) begin
    if (run_chk) begin
      check("model_leds",  {4'h0, leds},   {4'h0, m_leds});
      check("model_rsel",  {7'h0, rsel},   {7'h0, m_rsel});
      check("model_rdata", rdata,          m_rdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] o, input logic [7:0] d);
    addr  = BASE | {13'h0, o};
    wdata = d;
    we    = 1'b1;
    @(posedge sys_clk);
    #1;
    we   = 1'b0;
    addr = 16'h0000;
  endtask

  task automatic rd(input logic [2:0] o, output logic [7:0] d, output logic rs);
    addr = BASE | {13'h0, o};
    we   = 1'b0;
    @(posedge sys_clk);
    #1;
    d    = rdata;
    rs   = rsel;
    addr = 16'h0000;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_T(input int unsigned target, input int unsigned limit, input string name);
    int unsigned n = 0;
    while (m_T != target && n < limit) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check(name, {7'h0, m_T == target}, 8'h01);
  endtask

  initial begin
    logic [7:0] d;
    logic       rs;
    logic [7:0] r [5];
    logic [7:0] exp_rb [5];
    int         c0, c1, c2, n;
    logic [2:0] o;

    exp_rb[0] = 8'h11; exp_rb[1] = 8'h22; exp_rb[2] = 8'h33;
    exp_rb[3] = 8'h44; exp_rb[4] = 8'hF3;

    reset = 1'b1; addr = 16'h0000; wdata = 8'h00; we = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    reset   = 1'b0;
    run_chk = 1'b1;

    // Reset mid-run with CTRL=0x03 and an active read response
    wr(3'd0, 8'h80);
    wr(3'd4, 8'h03);
    idle(20);
    rd(3'd4, d, rs);
    check("pre_rst_rdata", d, 8'h03);
    check("pre_rst_rsel", {7'h0, rs}, 8'h01);
    reset = 1'b1;
    #1;
    check("rst_leds",  {4'h0, leds}, 8'h00);
    check("rst_rsel",  {7'h0, rsel}, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    rd(3'd4, d, rs);
    check("post_rst_ctrl", d, 8'h00);

    // Register readback
    wr(3'd0, 8'h11);
    check("wr_no_rsel", {7'h0, rsel}, 8'h00);
    wr(3'd1, 8'h22);
    wr(3'd2, 8'h33);
    wr(3'd3, 8'h44);
    wr(3'd4, 8'hFF);
    wr(3'd7, 8'hAA);
    wr(3'd6, 8'h55);
    for (int i = 0; i < 5; i++) begin
      rd(3'(i), d, rs);
      check("readback", d, exp_rb[i]);
      check("readback_rsel", {7'h0, rs}, 8'h01);
    end
    rd(3'd7, d, rs);
    check("read_off7", d, 8'h00);

    // PWM duty over one full period
    wr(3'd5, 8'h00);
    wr(3'd0, 8'h40);
    wr(3'd1, 8'h00);
    wr(3'd2, 8'hFF);
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h01);
    idle(2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 256; i++) begin
      c0 += int'(leds[0]);
      c1 += int'(leds[1]);
      c2 += int'(leds[2]);
      idle(1);
    end
    check("duty_40", 8'(c0), 8'd64);
    check("duty_00", 8'(c1), 8'd0);
    check("duty_ff", 8'(c2), 8'd255);

    // Write-to-LED latency
    wr(3'd0, 8'h00);
    idle(2);
    n = 0;
    while ((m_T % 256) != 16 && n < 300) begin
      idle(1);
      n++;
    end
    check("lat_wait", {7'h0, (m_T % 256) == 16}, 8'h01);
    wr(3'd0, 8'h80);
    check("lat_edge1", {7'h0, leds[0]}, 8'h00);
    idle(1);
    check("lat_edge2", {7'h0, leds[0]}, 8'h01);

    // Prescaler period and restart on rewrite
    wr(3'd5, 8'h03);
    for (int i = 0; i < 5; i++) rd(3'd6, r[i], rs);
    check("presc_hold", 8'(r[3] - r[0]), 8'h00);
    check("presc_step", 8'(r[4] - r[0]), 8'h01);
    wr(3'd5, 8'h03);
    for (int i = 0; i < 5; i++) rd(3'd6, r[i], rs);
    check("presc_restart_hold", 8'(r[3] - r[0]), 8'h00);
    check("presc_restart_step", 8'(r[4] - r[0]), 8'h01);

    // Blink gating and invert
    pulse_reset();
    wr(3'd3, 8'hFF);
    wr(3'd4, 8'h81);
    wait_T(32760, 40000, "blink_wait_on");
    check("blink_phase0", {7'h0, leds[3]}, 8'h01);
    wait_T(32776, 100, "blink_wait_off");
    check("blink_phase1", {7'h0, leds[3]}, 8'h00);
    wr(3'd4, 8'h83);
    idle(1);
    check("invert_blink", {4'h0, leds}, 8'h0F);
    wr(3'd4, 8'h02);
    idle(1);
    check("invert_disabled", {4'h0, leds}, 8'h0F);

    // Randomized traffic
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) addr = 16'($urandom);
      else                           addr = BASE | {13'h0, o};
      we    = 1'($urandom_range(0, 1));
      wdata = (addr[2:0] == 3'd5) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      reset = (i == 1500);
      @(posedge sys_clk);
      #1;
    end
    reset = 1'b0;
    we    = 1'b0;
    addr  = 16'h0000;
    idle(4);
    @(negedge sys_clk);
    #1;
    run_chk = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
